csa_accum_seq: RTL and testbench
================================

# csa_accum_seq

Sequencer that accumulates a stream of N-bit operands through a 3:2 carry-save stage, one operand per cycle. The running total is held in redundant form as a sum/carry register pair. On the last operand it resolves the pair to binary with a chunked carry-propagate adder, W bits per cycle. It sits between the SIKE field-arithmetic partial-product generators and the reduction stage, and feeds a long CSA compression chain with a simple valid/ready stream.

## Interface
- N, 222: operand width.
- W, 74: chunk width of the final carry-propagate adder. Must equal the width of one CSA slice (N/3).
- EXT, 3: guard bits. ACC_W = N+EXT. Up to 2^EXT operands are accumulated without loss.
- K (localparam), ceil(ACC_W/W): number of resolve cycles. K=4 at the defaults.
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand present.
- in_ready  out  1  block can accept an operand.
- in_data  in  N  operand, zero-extended to ACC_W.
- in_last  in  1  final operand of the current accumulation. Qualified by the in_valid&&in_ready handshake.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_data  out  ACC_W  binary sum mod 2^ACC_W.
- ovf  out  1  more than 2^EXT operands went into this result. Valid while out_valid=1.
- busy  out  1  state is not ACCUM, or at least one operand has been accepted in the current accumulation.

## Operation
- Registers:
  - S[ACC_W-1:0]: sum.
  - C[ACC_W-1:0]: carry, stored pre-shifted.
  - R[ACC_W-1:0]: result.
  - cnt[EXT:0]: saturating operand count.
  - cy: inter-chunk carry.
  - k: chunk index.
  - state.
- States are ACCUM, RESOLVE, DONE. Reset enters ACCUM with every register zero.
- ACCUM:
  - in_ready=1.
  - On each handshake, with x = zero-extended in_data:
    - S <= S^C^x.
    - C <= {maj(S,C,x)[ACC_W-2:0],1'b0}. The top majority bit is discarded (mod 2^ACC_W).
    - cnt <= min(cnt+1, 2^(EXT+1)-1).
  - Handshake with in_last=1 performs the compression above, then goes to RESOLVE with k=0, cy=0.
  - in_valid=0 leaves everything unchanged.
- RESOLVE:
  - in_ready=0.
  - Each cycle: {cy, R[chunk k]} <= S[chunk k] + C[chunk k] + cy, then k <= k+1.
  - The last chunk is ACC_W-(K-1)·W bits wide; its carry-out is discarded.
  - After chunk K-1, go to DONE.
- DONE:
  - out_valid=1, out_data=R, ovf=(cnt > 2^EXT), in_ready=0.
  - On out_ready=1: clear S, C, cnt and cy, then go to ACCUM.
- The handshake with in_last is the only way to close an accumulation. A single in_last beat yields that operand unchanged.
- Outputs outside DONE: out_valid=0, ovf=0. out_data holds the last R and is don't-care.
- rst in any state, including mid-RESOLVE or DONE: the next state is ACCUM with all registers zero. The pending result is discarded.

## Timing
- Reset values:
  - in_ready=1 in the first cycle after rst deasserts. It is 0 while rst=1.
  - out_valid=0, out_data=0, ovf=0, busy=0.
- Throughput: one operand per cycle while in ACCUM.
- Latency: in_last handshake in cycle t → out_valid first high in cycle t+K+1 (t+5 at the defaults). RESOLVE occupies cycles t+1..t+K.
- Output handshake in cycle u → in_ready=1 in cycle u+1. The minimum gap between accumulations is therefore K+1 cycles plus back-pressure.
- While out_valid=1 and out_ready=0, out_data and ovf are held stable.
- in_valid and in_data are ignored whenever in_ready=0.
- All outputs come straight from registers. There is no combinational path from in_* or out_ready to any output.

## Test plan
- Reset: assert rst for 3 cycles mid-stream, then release → cycle after release shows in_ready=1, out_valid=0, ovf=0, busy=0.
- Basic sum: operands 1, 2, 3, with in_last on 3, back to back in cycles t-2..t → out_valid first high in cycle t+5 with out_data=6 and ovf=0. out_ready=1 → in_ready=1 in the next cycle.
- Inter-chunk carry: operands 2^74-1 then 1 → 2^74. Then operands 2^222-1 then 1 → 2^222, exercising carry across all K chunks.
- Guard bits:
  - 8 operands of 2^222-1 → 2^225-8, ovf=0.
  - 9 such operands → (9·(2^222-1)) mod 2^225, ovf=1.
  - The following accumulation of a single operand 7 → 7, ovf=0.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 → out_data stable, in_ready=0, no operand absorbed. The next result equals only operands sent after the handshake.
- Reset mid-RESOLVE: rst in cycle t+2 after an in_last handshake → no out_valid. A later single operand 5 with in_last → out_data=5.

Source files
------------

// File: rtl/csa_accum_seq_if.sv
// Stream interface for csa_accum_seq.
// Operand side: in_valid/in_ready handshake that carries in_data and in_last.
// Result side: out_valid/out_ready handshake that carries out_data and ovf.
// busy reports an accumulation in progress.
// The slave modport is the accumulator. The master modport is the producer/consumer.
interface csa_accum_seq_if #(
    parameter int unsigned N   = 222,
    parameter int unsigned EXT = 3
);
    localparam int unsigned ACC_W = N + EXT;

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             ovf;
    logic             busy;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output ovf,
        output busy
    );

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  ovf,
        input  busy
    );
endinterface

// File: rtl/csa_accum_seq.sv
// Carry-save accumulating sequencer.
// Operands are folded into a redundant sum/carry pair by a 3:2 compressor, one per cycle.
// On the in_last beat, the pair is resolved to binary by a chunked carry-propagate adder.
// The adder handles W bits per cycle over K cycles. The result is then offered on the output stream.
// Ports:
//   clk  - clock; all state changes on the rising edge
//   rst  - synchronous, active-high reset
//   bus  - csa_accum_seq_if.slave: in_valid/in_ready/in_data/in_last,
//          out_valid/out_ready/out_data/ovf, busy
module csa_accum_seq #(
    parameter int unsigned N   = 222,
    parameter int unsigned W   = 74,
    parameter int unsigned EXT = 3
) (
    input logic            clk,
    input logic            rst,
    csa_accum_seq_if.slave bus
);
    localparam int unsigned ACC_W = N + EXT;
    localparam int unsigned K     = (ACC_W + W - 1) / W;
    localparam int unsigned KW    = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned PW    = K * W;

    localparam logic [EXT:0] CntMax = '1;
    localparam logic [EXT:0] CntOne = {{EXT{1'b0}}, 1'b1};
    // 2^EXT: the largest lossless operand count.
    localparam logic [EXT:0] CntLim = {1'b1, {EXT{1'b0}}};

    typedef enum logic [1:0] {StAccum, StResolve, StDone} state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] s_q, s_d;
    logic [ACC_W-1:0] c_q, c_d;
    logic [ACC_W-1:0] r_q, r_d;
    logic [EXT:0]     cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic [KW-1:0]    k_q, k_d;
    logic             in_ready_q;

    logic             accept;
    logic [ACC_W-1:0] x;
    logic [ACC_W-1:0] maj;
    logic [PW-1:0]    s_pad, c_pad;
    logic [W-1:0]     s_chunk, c_chunk;
    logic [W:0]       chunk_sum;

    // in_ready is registered so that it is low throughout reset
    // and has no path from any input.
    assign accept = bus.in_valid && in_ready_q;
    assign x      = ACC_W'(bus.in_data);
    assign maj    = (s_q & c_q) | (s_q & x) | (c_q & x);

    // The chunks are zero-padded to K*W bits.
    // The narrow top chunk therefore uses the same adder as the others.
    assign s_pad     = PW'(s_q);
    assign c_pad     = PW'(c_q);
    assign s_chunk   = s_pad[k_q*W +: W];
    assign c_chunk   = c_pad[k_q*W +: W];
    assign chunk_sum = (W+1)'(s_chunk) + (W+1)'(c_chunk) + (W+1)'(cy_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StAccum;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == StAccum);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAccum:   if (accept && bus.in_last) state_d = StResolve;
            StResolve: if (k_q == KW'(K - 1))     state_d = StDone;
            StDone:    if (bus.out_ready)         state_d = StAccum;
            default:   state_d = StAccum;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q   <= '0;
            c_q   <= '0;
            r_q   <= '0;
            cnt_q <= '0;
            cy_q  <= 1'b0;
            k_q   <= '0;
        end else begin
            s_q   <= s_d;
            c_q   <= c_d;
            r_q   <= r_d;
            cnt_q <= cnt_d;
            cy_q  <= cy_d;
            k_q   <= k_d;
        end
    end

    // Datapath next-state
    always_comb begin
        s_d   = s_q;
        c_d   = c_q;
        r_d   = r_q;
        cnt_d = cnt_q;
        cy_d  = cy_q;
        k_d   = k_q;
        unique case (state_q)
            StAccum: begin
                if (accept) begin
                    s_d = s_q ^ c_q ^ x;
                    // The carry is stored pre-shifted. The top majority bit falls off (mod 2^ACC_W).
                    c_d = {maj[ACC_W-2:0], 1'b0};
                    if (cnt_q != CntMax) cnt_d = cnt_q + CntOne;
                    if (bus.in_last) begin
                        k_d  = '0;
                        cy_d = 1'b0;
                    end
                end
            end
            StResolve: begin
                for (int unsigned i = 0; i < ACC_W; i++) begin
                    if (k_q == KW'(i / W)) r_d[i] = chunk_sum[i % W];
                end
                // The carry-out of the last chunk is dropped on the way to DONE.
                cy_d = chunk_sum[W];
                k_d  = k_q + KW'(1);
            end
            StDone: begin
                if (bus.out_ready) begin
                    s_d   = '0;
                    c_d   = '0;
                    cnt_d = '0;
                    cy_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Outputs: decoded from registers only
    always_comb begin
        bus.in_ready  = in_ready_q;
        bus.out_valid = (state_q == StDone);
        bus.out_data  = r_q;
        bus.ovf       = (state_q == StDone) && (cnt_q > CntLim);
        bus.busy      = (state_q != StAccum) || (cnt_q != '0);
    end
endmodule

// File: tb/tb_csa_accum_seq.sv
// Self-checking bench for csa_accum_seq.
// It runs table-driven accumulations through a result scoreboard, followed by reset,
// back-pressure and mid-resolve reset sequences.
module tb_csa_accum_seq;
    localparam int unsigned N     = 222;
    localparam int unsigned W     = 74;
    localparam int unsigned EXT   = 3;
    localparam int unsigned ACC_W = N + EXT;
    localparam int unsigned LAT   = 5;  // in_last handshake to first out_valid

    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic             ovf;
        int unsigned      cyc;
    } exp_t;

    typedef struct packed {
        int unsigned        n;
        logic [3:0][N-1:0]  ops;  // operand i uses ops[min(i,3)]
        logic [ACC_W-1:0]   exp;
        logic               ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    bit          seen = 1'b0;
    bit          chk_ready = 1'b0;
    vec_t        vecs [6];

    csa_accum_seq_if #(.N(N), .EXT(EXT)) bus ();

    csa_accum_seq #(.N(N), .W(W), .EXT(EXT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [ACC_W-1:0] act,
                         input logic [ACC_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int unsigned n, input logic [N-1:0] a,
                                input logic [N-1:0] b, input logic [N-1:0] c,
                                input logic [N-1:0] d, input logic [ACC_W-1:0] e,
                                input logic o);
        vec_t v;
        v.n      = n;
        v.ops[0] = a;
        v.ops[1] = b;
        v.ops[2] = c;
        v.ops[3] = d;
        v.exp    = e;
        v.ovf    = o;
        return v;
    endfunction

    // Called and returns at posedge+#1. Holds the operand until it is accepted.
    task automatic drive_op(input logic [N-1:0] op, input logic last,
                            input logic [ACC_W-1:0] exp, input logic exp_ovf);
        int unsigned w = 0;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_data  = op;
        bus.in_last  = last;
        @(negedge clk);
        while (!bus.in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", w);
        end else if (last) begin
            e.data = exp;
            e.ovf  = exp_ovf;
            e.cyc  = cyc + LAT;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Output monitor: this block compares the first cycle of every result against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            seen      = 1'b0;
            chk_ready = 1'b0;
        end else begin
            if (chk_ready) begin
                check("in_ready_after_out", ACC_W'(bus.in_ready), ACC_W'(1));
                check("out_valid_dropped", ACC_W'(bus.out_valid), ACC_W'(0));
                chk_ready = 1'b0;
            end
            if (bus.out_valid && !seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: out_valid=1 data %0h, expected no result",
                             bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", bus.out_data, e.data);
                    check("ovf", ACC_W'(bus.ovf), ACC_W'(e.ovf));
                    check("latency_cycle", ACC_W'(cyc), ACC_W'(e.cyc));
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                seen      = 1'b0;
                chk_ready = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0]     ones;
        logic [N-1:0]     m74;
        logic [ACC_W-1:0] one_acc;
        logic [N-1:0]     op;
        logic [1:0]       idx;

        ones    = '1;
        m74     = (N'(1) << W) - N'(1);
        one_acc = ACC_W'(1);
        vecs[0] = mk(3, N'(1), N'(2), N'(3), N'(3), ACC_W'(6), 1'b0);
        vecs[1] = mk(2, m74, N'(1), N'(1), N'(1), one_acc << W, 1'b0);
        vecs[2] = mk(2, ones, N'(1), N'(1), N'(1), one_acc << N, 1'b0);
        vecs[3] = mk(8, ones, ones, ones, ones, ~ACC_W'(7), 1'b0);
        vecs[4] = mk(9, ones, ones, ones, ones, (one_acc << N) - ACC_W'(9), 1'b1);
        vecs[5] = mk(1, N'(7), N'(7), N'(7), N'(7), ACC_W'(7), 1'b0);

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready_low", ACC_W'(bus.in_ready), ACC_W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("por_in_ready", ACC_W'(bus.in_ready), ACC_W'(1));
        check("por_out_valid", ACC_W'(bus.out_valid), ACC_W'(0));
        check("por_ovf", ACC_W'(bus.ovf), ACC_W'(0));
        check("por_busy", ACC_W'(bus.busy), ACC_W'(0));
        check("por_out_data", bus.out_data, ACC_W'(0));
        @(posedge clk);
        #1;

        // Mid-stream reset held for 3 cycles
        drive_op(N'(1), 1'b0, '0, 1'b0);
        drive_op(N'(2), 1'b0, '0, 1'b0);
        @(negedge clk);
        check("busy_mid_stream", ACC_W'(bus.busy), ACC_W'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_mid_in_ready", ACC_W'(bus.in_ready), ACC_W'(0));
        check("rst_mid_busy", ACC_W'(bus.busy), ACC_W'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rel_in_ready", ACC_W'(bus.in_ready), ACC_W'(1));
        check("rel_out_valid", ACC_W'(bus.out_valid), ACC_W'(0));
        check("rel_ovf", ACC_W'(bus.ovf), ACC_W'(0));
        check("rel_busy", ACC_W'(bus.busy), ACC_W'(0));
        @(posedge clk);
        #1;

        // Table-driven accumulations
        for (int v = 0; v < 6; v++) begin
            for (int unsigned i = 0; i < vecs[v].n; i++) begin
                idx = (i < 4) ? 2'(i) : 2'd3;
                op  = vecs[v].ops[idx];
                drive_op(op, (i == vecs[v].n - 1), vecs[v].exp, vecs[v].ovf);
            end
            wait_drain();
        end

        // Back-pressure: the result is held while operands are presented and ignored
        bus.out_ready = 1'b0;
        drive_op(N'(10), 1'b1, ACC_W'(10), 1'b0);
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = N'(99);
            bus.in_last  = 1'b1;
            @(negedge clk);
            check("bp_out_valid", ACC_W'(bus.out_valid), ACC_W'(1));
            check("bp_out_data", bus.out_data, ACC_W'(10));
            check("bp_in_ready", ACC_W'(bus.in_ready), ACC_W'(0));
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain();
        drive_op(N'(4), 1'b1, ACC_W'(4), 1'b0);
        wait_drain();

        // Reset during RESOLVE: the pending result is discarded
        drive_op(N'(9), 1'b0, '0, 1'b0);
        drive_op(N'(11), 1'b1, ACC_W'(20), 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_resolve_no_out", ACC_W'(bus.out_valid), ACC_W'(0));
            @(posedge clk);
            #1;
        end
        drive_op(N'(5), 1'b1, ACC_W'(5), 1'b0);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
